// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;
    localparam logic [31:0] ERR_INST          = 32'h0;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake between the core (master) and the responder (slave).
interface imem_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [INST_WIDTH-1:0] resp_inst;
    logic                  resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err
    );
endinterface

// File: rtl/imem_array.sv
// Instruction store: synchronous write port, combinational read port.
module imem_array #(
    parameter int DEPTH      = 1024,
    parameter int INST_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [INST_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [INST_WIDTH-1:0] rd_data
);

    logic [INST_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Read sees pre-edge contents, so a same-edge write returns the old word.
    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts one address, waits LATENCY cycles, returns the word
// (or an error for misaligned/out-of-range fetches) under valid/ready.
module imem_responder
    import imem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter int                    LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
    input  logic                     clk,
    input  logic                     rst,
    imem_responder_if.slave          bus,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [INST_WIDTH-1:0]    wr_data
);

    localparam int                    IDX_W = $clog2(DEPTH);
    localparam int                    CNT_W = 4;
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH) << 2;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("imem_responder: LATENCY must be in 1..15");
    end

    imem_state_e           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic [INST_WIDTH-1:0] resp_inst_q;
    logic                  resp_err_q;

    logic [ADDR_WIDTH-1:0] chk_addr;
    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      rd_idx;
    logic [INST_WIDTH-1:0] rd_data;
    logic [INST_WIDTH-1:0] inst_d;
    logic                  err_d;

    imem_array #(
        .DEPTH      (DEPTH),
        .INST_WIDTH (INST_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // With LATENCY=1 the read latches on the accept edge, straight from the bus.
    always_comb begin
        chk_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
        off      = chk_addr - BASE_ADDR;
        err_d    = (chk_addr[1:0] != 2'b00) || (chk_addr < BASE_ADDR) || (off >= SPAN);
        rd_idx   = off[IDX_W+1:2];
        inst_d   = err_d ? INST_WIDTH'(ERR_INST) : rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_inst_q  <= inst_d;
                            resp_err_q   <= err_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= RESP;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_inst_q  <= inst_d;
                        resp_err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_inst  = resp_inst_q;
    assign bus.resp_err   = resp_err_q;

endmodule
